// File: rtl/uart_program_loader.sv
// UART program loader: receives an A5-framed, length-prefixed image (8N1) and writes it to RAM as big-endian 32-bit words.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module uart_program_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [15:0] BASE_ADDR    = 16'h0,
    parameter int unsigned TIMEOUT_CLKS = 5000000
) (
    input  logic        physical_clock,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        ram_wb_flag,
    output logic [15:0] ram_wb_addr,
    output logic [31:0] ram_wb_data,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);
    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {F_SYNC, F_LEN_HI, F_LEN_LO, F_DATA, F_CSUM, F_END} f_state_t;
    localparam f_state_t F_TERM = F_CSUM;
`else
    typedef enum logic [2:0] {F_SYNC, F_LEN_HI, F_LEN_LO, F_DATA, F_END} f_state_t;
    localparam f_state_t F_TERM = F_END;
`endif

    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_valid, frame_err;

    f_state_t      f_state_q, f_state_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   idx_q, idx_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [23:0]   buf_q, buf_d;
    logic [31:0]   gap_q, gap_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif
    logic          wb_flag_q, wb_flag_d;
    logic [15:0]   wb_addr_q, wb_addr_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [15:0]   words_q, words_d;

    // byte_valid/shift_q form a one-cycle strobe with no backpressure: the frame FSM
    // consumes every byte on the cycle it is offered; frame_err is the matching drop strobe.
    always_comb begin
        rx_state_d = rx_state_q;
        clk_cnt_d  = clk_cnt_q + CW'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                clk_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = R_START;
            end
            R_START: if (clk_cnt_q == CW'(HALF_BIT - 1)) begin
                clk_cnt_d  = '0;
                bit_idx_d  = '0;
                rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
            end
            R_DATA: if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                clk_cnt_d = '0;
                shift_d   = {rx_sync_q, shift_q[7:1]};
                bit_idx_d = bit_idx_q + 3'd1;
                if (bit_idx_q == 3'd7) rx_state_d = R_STOP;
            end
            R_STOP: if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                clk_cnt_d  = '0;
                byte_valid = rx_sync_q;
                frame_err  = !rx_sync_q;
                rx_state_d = R_IDLE;
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        f_state_d  = f_state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        buf_d      = buf_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        wb_flag_d  = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        words_d    = words_q;
        gap_d      = (f_state_q == F_SYNC || byte_valid) ? 32'd0 : gap_q + 32'd1;

        if (frame_err || (f_state_q != F_SYNC && gap_q > TIMEOUT_CLKS)) begin
            error_d   = 1'b1;
            busy_d    = 1'b0;
            f_state_d = F_SYNC;
        end else if (f_state_q == F_END) begin
            done_d    = !error_q;
            busy_d    = 1'b0;
            f_state_d = F_SYNC;
        end else if (byte_valid) begin
            case (f_state_q)
                F_SYNC: if (shift_q == 8'hA5) begin
                    error_d    = 1'b0;
                    words_d    = '0;
                    busy_d     = 1'b1;
                    idx_d      = '0;
                    byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    f_state_d  = F_LEN_HI;
                end
                F_LEN_HI: begin
                    len_d     = {shift_q, 8'h00};
                    f_state_d = F_LEN_LO;
                end
                F_LEN_LO: begin
                    len_d     = {len_q[15:8], shift_q};
                    f_state_d = ({len_q[15:8], shift_q} == 16'd0) ? F_TERM : F_DATA;
                end
                F_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ shift_q;
`endif
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    buf_d      = {buf_q[15:0], shift_q};
                    if (byte_cnt_q == 2'd3) begin
                        wb_flag_d = 1'b1;
                        wb_addr_d = BASE_ADDR + idx_q;
                        wb_data_d = {buf_q, shift_q};
                        words_d   = words_q + 16'd1;
                        idx_d     = idx_q + 16'd1;
                        if (idx_q + 16'd1 == len_q) f_state_d = F_TERM;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                F_CSUM: begin
                    if (shift_q == csum_q) begin
                        f_state_d = F_END;
                    end else begin
                        error_d   = 1'b1;
                        busy_d    = 1'b0;
                        f_state_d = F_SYNC;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge physical_clock) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= R_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            f_state_q  <= F_SYNC;
            len_q      <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            buf_q      <= '0;
            gap_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
            wb_flag_q  <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            words_q    <= '0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            f_state_q  <= f_state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            buf_q      <= buf_d;
            gap_q      <= gap_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
            wb_flag_q  <= wb_flag_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            words_q    <= words_d;
        end
    end

    assign ram_wb_flag  = wb_flag_q;
    assign ram_wb_addr  = wb_addr_q;
    assign ram_wb_data  = wb_data_q;
    assign load_busy    = busy_q;
    assign load_done    = done_q;
    assign load_error   = error_q;
    assign words_loaded = words_q;
endmodule
